highscore_table: RTL

- Parametrised top-N high-score table for the game.
- Holds DEPTH scores sorted in descending order in registers.
- On each entry into the game's Done state, captures the final score. If the score qualifies, it is inserted at its rank and lower entries shift down one slot.
- Feeds the score/HUD display logic through a random-access read port and a best-score output.

---
 rtl/highscore_table_if.sv | 28 ++
 rtl/highscore_table.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/highscore_table_if.sv
// Bus between the game/HUD logic and the high-score table: score capture,
// game-state trigger, clear, random-access read and insertion status.
interface highscore_table_if #(
  parameter int SCORE_W = 32,
  parameter int STATE_W = 3,
  parameter int IDX_W   = 3
);
  logic [SCORE_W-1:0] score;
  logic [STATE_W-1:0] state;
  logic               clear;
  logic [IDX_W-1:0]   rd_index;
  logic [SCORE_W-1:0] rd_score;
  logic [SCORE_W-1:0] best_score;
  logic               busy;
  logic               ins_done;
  logic               ins_valid;
  logic [IDX_W-1:0]   ins_rank;

  modport master (
    output score, state, clear, rd_index,
    input  rd_score, best_score, busy, ins_done, ins_valid, ins_rank
  );

  modport slave (
    input  score, state, clear, rd_index,
    output rd_score, best_score, busy, ins_done, ins_valid, ins_rank
  );
endinterface

// File: rtl/highscore_table.sv
// Top-N high-score table kept sorted descending in registers; a rising entry
// into the Done game state scans for the new score's rank and inserts it.
module highscore_table #(
  parameter int                   DEPTH      = 5,
  parameter int                   SCORE_W    = 32,
  parameter int                   STATE_W    = 3,
  parameter logic [STATE_W-1:0]   DONE_STATE = STATE_W'(3),
  localparam int                  IDX_W      = $clog2(DEPTH + 1)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  highscore_table_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT,
    S_WRITE,
    S_REPORT
  } fsm_e;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  fsm_e               fsm_q, fsm_d;
  logic [SCORE_W-1:0] tbl_q [DEPTH];
  logic [SCORE_W-1:0] tbl_d [DEPTH];
  logic [STATE_W-1:0] prev_state_q;
  logic [SCORE_W-1:0] cand_q, cand_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic               ins_valid_q, ins_valid_d;
  logic [IDX_W-1:0]   ins_rank_q, ins_rank_d;

  logic               trigger;
  logic [SCORE_W-1:0] scan_val;
  logic [SCORE_W-1:0] rd_val;

  assign trigger = (fsm_q == S_IDLE) && (bus.state == DONE_STATE)
                 && (prev_state_q != DONE_STATE);

  // Slot muxes; out-of-range read indices return 0.
  always_comb begin
    scan_val = '0;
    rd_val   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == IDX_W'(i))        scan_val = tbl_q[i];
      if (bus.rd_index == IDX_W'(i)) rd_val   = tbl_q[i];
    end
  end

  // NOTE: every _d signal takes its _q value first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    fsm_d       = fsm_q;
    tbl_d       = tbl_q;
    cand_d      = cand_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    j_d         = j_q;
    ins_valid_d = ins_valid_q;
    ins_rank_d  = ins_rank_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (trigger) begin
          cand_d      = bus.score;
          idx_d       = '0;
          ins_valid_d = 1'b0;
          ins_rank_d  = DEPTH_IDX;
          fsm_d       = S_SCAN;
        end else if (bus.clear) begin
          for (int i = 0; i < DEPTH; i++) tbl_d[i] = '0;
        end
      end

      // Strict compare: equal scores stay above the newcomer.
      S_SCAN: begin
        if (cand_q > scan_val) begin
          pos_d = idx_q;
          j_d   = LAST_IDX;
          fsm_d = (idx_q == LAST_IDX) ? S_WRITE : S_SHIFT;
        end else if (idx_q == LAST_IDX) begin
          ins_valid_d = 1'b0;
          ins_rank_d  = DEPTH_IDX;
          fsm_d       = S_REPORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_SHIFT: begin
        for (int i = 1; i < DEPTH; i++) begin
          if (j_q == IDX_W'(i)) tbl_d[i] = tbl_q[i-1];
        end
        if (j_q == pos_q + IDX_W'(1)) fsm_d = S_WRITE;
        else                          j_d   = j_q - IDX_W'(1);
      end

      S_WRITE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (pos_q == IDX_W'(i)) tbl_d[i] = cand_q;
        end
        ins_valid_d = 1'b1;
        ins_rank_d  = pos_q;
        fsm_d       = S_REPORT;
      end

      S_REPORT: fsm_d = S_IDLE;

      default:  fsm_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm_q        <= S_IDLE;
      // NOTE: the score registers are reset as well; an empty slot must read 0 from power-up.
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      prev_state_q <= '0;
      cand_q       <= '0;
      idx_q        <= '0;
      pos_q        <= '0;
      j_q          <= '0;
      ins_valid_q  <= 1'b0;
      ins_rank_q   <= DEPTH_IDX;
    end else begin
      fsm_q        <= fsm_d;
      tbl_q        <= tbl_d;
      prev_state_q <= bus.state;
      cand_q       <= cand_d;
      idx_q        <= idx_d;
      pos_q        <= pos_d;
      j_q          <= j_d;
      ins_valid_q  <= ins_valid_d;
      ins_rank_q   <= ins_rank_d;
    end
  end

  // REPORT is the completion cycle, so busy covers only SCAN/SHIFT/WRITE.
  assign bus.busy       = (fsm_q == S_SCAN) || (fsm_q == S_SHIFT) || (fsm_q == S_WRITE);
  assign bus.ins_done   = (fsm_q == S_REPORT);
  assign bus.ins_valid  = ins_valid_q;
  assign bus.ins_rank   = ins_rank_q;
  assign bus.rd_score   = rd_val;
  assign bus.best_score = tbl_q[0];

endmodule
